dma_mem_port: RTL and testbench

Memory-side responder for the AFU DMA word stream: a DEPTH-word dual-access scratchpad window that the DMA engine writes incoming host cache lines into and reads outgoing lines from, one 32-bit word per access. The CPU shares the same window through a stallable port. A small doorbell/status FSM tells the CPU when a full line has landed and raises `wr_ready` to the DMA engine when the CPU requests a write-back to the host.

---
 rtl/dma_mem_port.sv | 214 +++++++++++++++++++++
 tb/tb_dma_mem_port.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_mem_port.sv
// DMA/CPU shared scratchpad window with line-received doorbell/status FSM.
// Optional out-of-window error flag: define DMA_MEM_PORT_OOB_ERR_EN.
module dma_mem_port #(
  parameter logic [31:0] BASE_ADDR = 32'h5000,
  parameter int          DEPTH     = 16,
  parameter int          WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 DMAEn,
  input  logic                 DMAWrEn,
  input  logic [31:0]          DMAAddr,
  input  logic [WORD_SIZE-1:0] data_to_mem,
  output logic [WORD_SIZE-1:0] data_to_host,
  output logic                 wr_ready,
  input  logic                 cpu_en,
  input  logic                 cpu_wr_en,
  input  logic [31:0]          cpu_addr,
  input  logic [WORD_SIZE-1:0] cpu_wdata,
  output logic [WORD_SIZE-1:0] cpu_rdata,
  output logic                 cpu_stall,
`ifdef DMA_MEM_PORT_OOB_ERR_EN
  output logic                 oob_err,
`endif
  output logic                 line_irq
);

  localparam int          AW           = $clog2(DEPTH);
  localparam int          TW           = $clog2(DEPTH + 1);
  localparam logic [29:0] DOORBELL_IDX = 30'(DEPTH);
  localparam logic [29:0] STATUS_IDX   = 30'(DEPTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, TX_REQ = 2'd1, TX = 2'd2} state_t;

  logic [WORD_SIZE-1:0] mem_q [DEPTH];
  state_t               state_q, state_d;
  logic [TW-1:0]        tx_count_q, tx_count_d;
  logic [AW-1:0]        rx_count_q, rx_count_d;
  logic                 line_irq_q, line_irq_d;
  logic                 overrun_q, overrun_d;
  logic                 wr_ready_q, wr_ready_d;
  logic [WORD_SIZE-1:0] data_to_host_q, data_to_host_d;
  logic [WORD_SIZE-1:0] cpu_rdata_q, cpu_rdata_d;
  logic                 oob_q, oob_d;

  logic [29:0]          dma_idx_s, cpu_idx_s;
  logic                 dma_in_win_s, cpu_in_win_s;
  logic                 dma_wr_s, dma_rd_s, cpu_acc_s, cpu_wr_s, cpu_rd_s;
  logic                 doorbell_s, status_wr_s, wrap_s;
  logic                 mem_we_s;
  logic [AW-1:0]        mem_waddr_s;
  logic [WORD_SIZE-1:0] mem_wdata_s, status_s;

  // Decode both ports; the CPU only gets through when the DMA is idle.
  always_comb begin
    dma_idx_s    = 30'((DMAAddr - BASE_ADDR) >> 2);
    cpu_idx_s    = 30'((cpu_addr - BASE_ADDR) >> 2);
    dma_in_win_s = dma_idx_s < 30'(DEPTH);
    cpu_in_win_s = cpu_idx_s < 30'(DEPTH);
    dma_wr_s     = DMAEn & DMAWrEn & dma_in_win_s;
    dma_rd_s     = DMAEn & ~DMAWrEn;
    cpu_stall    = cpu_en & DMAEn;
    cpu_acc_s    = cpu_en & ~DMAEn;
    cpu_wr_s     = cpu_acc_s & cpu_wr_en;
    cpu_rd_s     = cpu_acc_s & ~cpu_wr_en;
    doorbell_s   = cpu_wr_s & (cpu_idx_s == DOORBELL_IDX);
    status_wr_s  = cpu_wr_s & (cpu_idx_s == STATUS_IDX);
    mem_we_s     = dma_wr_s | (cpu_wr_s & cpu_in_win_s);
    mem_waddr_s  = dma_wr_s ? dma_idx_s[AW-1:0] : cpu_idx_s[AW-1:0];
    mem_wdata_s  = dma_wr_s ? data_to_mem : cpu_wdata;
    status_s     = '0;
    status_s[0]  = line_irq_q;
    status_s[1]  = (state_q != IDLE);
    status_s[2]  = overrun_q;
    status_s[3 +: AW] = rx_count_q;
`ifdef DMA_MEM_PORT_OOB_ERR_EN
    status_s[3 + AW]  = oob_q;
`endif
  end

  // Registered read paths; data holds between reads.
  always_comb begin
    data_to_host_d = data_to_host_q;
    cpu_rdata_d    = cpu_rdata_q;
    if (dma_rd_s) begin
      data_to_host_d = dma_in_win_s ? mem_q[dma_idx_s[AW-1:0]] : '0;
    end else begin
      data_to_host_d = data_to_host_q;
    end
    if (cpu_rd_s) begin
      if (cpu_in_win_s) cpu_rdata_d = mem_q[cpu_idx_s[AW-1:0]];
      else if (cpu_idx_s == STATUS_IDX) cpu_rdata_d = status_s;
      else cpu_rdata_d = '0;
    end else begin
      cpu_rdata_d = cpu_rdata_q;
    end
  end

  // Write-back FSM: doorbell -> request -> count DEPTH outgoing reads.
  always_comb begin
    state_d    = state_q;
    tx_count_d = tx_count_q;
    case (state_q)
      IDLE: begin
        if (doorbell_s) state_d = TX_REQ;
        else state_d = IDLE;
      end
      TX_REQ: begin
        if (dma_rd_s & dma_in_win_s) begin
          state_d    = TX;
          tx_count_d = TW'(1);
        end else begin
          state_d = TX_REQ;
        end
      end
      TX: begin
        if (dma_rd_s) begin
          if (tx_count_q + TW'(1) == TW'(DEPTH)) begin
            state_d    = IDLE;
            tx_count_d = '0;
          end else begin
            tx_count_d = tx_count_q + TW'(1);
          end
        end else begin
          tx_count_d = tx_count_q;
        end
      end
      default: begin
        state_d    = IDLE;
        tx_count_d = '0;
      end
    endcase
    wr_ready_d = (state_d == TX_REQ);
  end

  // Incoming line counter and sticky flags; a set in the same cycle beats a clear.
  always_comb begin
    rx_count_d = rx_count_q;
    wrap_s     = 1'b0;
    line_irq_d = line_irq_q;
    overrun_d  = overrun_q;
    oob_d      = oob_q;
    if (dma_wr_s) begin
      if (rx_count_q == AW'(DEPTH - 1)) begin
        rx_count_d = '0;
        wrap_s     = 1'b1;
      end else begin
        rx_count_d = rx_count_q + AW'(1);
      end
    end else begin
      rx_count_d = rx_count_q;
    end
    if (status_wr_s & cpu_wdata[0]) begin
      line_irq_d = 1'b0;
      overrun_d  = 1'b0;
    end else begin
      line_irq_d = line_irq_q;
    end
    if (wrap_s) begin
      line_irq_d = 1'b1;
      if (line_irq_q) overrun_d = 1'b1;
      else overrun_d = overrun_d;
    end else begin
      line_irq_d = line_irq_d;
    end
`ifdef DMA_MEM_PORT_OOB_ERR_EN
    if (status_wr_s & cpu_wdata[1]) oob_d = 1'b0;
    else oob_d = oob_q;
    if ((DMAEn & ~dma_in_win_s) | (cpu_acc_s & (cpu_idx_s > STATUS_IDX))) oob_d = 1'b1;
    else oob_d = oob_d;
`else
    oob_d = 1'b0;
`endif
  end

  // Scratchpad storage, intentionally not reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) mem_q[mem_waddr_s] <= mem_wdata_s;
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      tx_count_q     <= '0;
      rx_count_q     <= '0;
      line_irq_q     <= 1'b0;
      overrun_q      <= 1'b0;
      oob_q          <= 1'b0;
      wr_ready_q     <= 1'b0;
      data_to_host_q <= '0;
      cpu_rdata_q    <= '0;
    end else begin
      state_q        <= state_d;
      tx_count_q     <= tx_count_d;
      rx_count_q     <= rx_count_d;
      line_irq_q     <= line_irq_d;
      overrun_q      <= overrun_d;
      oob_q          <= oob_d;
      wr_ready_q     <= wr_ready_d;
      data_to_host_q <= data_to_host_d;
      cpu_rdata_q    <= cpu_rdata_d;
    end
  end

  assign data_to_host = data_to_host_q;
  assign cpu_rdata    = cpu_rdata_q;
  assign wr_ready     = wr_ready_q;
  assign line_irq     = line_irq_q;
`ifdef DMA_MEM_PORT_OOB_ERR_EN
  assign oob_err      = oob_q;
`endif

endmodule

// File: tb/tb_dma_mem_port.sv
// Directed table-driven bench for dma_mem_port plus hand-written corner sequences.
module tb_dma_mem_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        DMAEn, DMAWrEn, cpu_en, cpu_wr_en;
  logic [31:0] DMAAddr, data_to_mem, cpu_addr, cpu_wdata;
  logic [31:0] data_to_host, cpu_rdata;
  logic        wr_ready, cpu_stall, line_irq;
`ifdef DMA_MEM_PORT_OOB_ERR_EN
  logic        oob_err;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dma_mem_port dut (
    .clk(clk), .rst_n(rst_n),
    .DMAEn(DMAEn), .DMAWrEn(DMAWrEn), .DMAAddr(DMAAddr),
    .data_to_mem(data_to_mem), .data_to_host(data_to_host), .wr_ready(wr_ready),
    .cpu_en(cpu_en), .cpu_wr_en(cpu_wr_en), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
`ifdef DMA_MEM_PORT_OOB_ERR_EN
    .oob_err(oob_err),
`endif
    .line_irq(line_irq)
  );

  typedef struct {
    logic        dma_en, dma_wr;
    logic [31:0] dma_addr, dma_wdata;
    logic        cpu_en, cpu_wr;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        chk_dth;
    logic [31:0] exp_dth;
    logic        chk_crd;
    logic [31:0] exp_crd;
    logic        exp_wr_ready, exp_irq, exp_stall;
  } vec_t;

  vec_t vecs[37];

`ifdef DMA_MEM_PORT_OOB_ERR_EN
  localparam logic [31:0] OOB_BIT = 32'h80;
`else
  localparam logic [31:0] OOB_BIT = 32'h0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    DMAEn = 1'b0; DMAWrEn = 1'b0; DMAAddr = 32'h0; data_to_mem = 32'h0;
    cpu_en = 1'b0; cpu_wr_en = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dma_wr(input logic [31:0] a, input logic [31:0] d);
    DMAEn = 1'b1; DMAWrEn = 1'b1; DMAAddr = a; data_to_mem = d;
    tick();
    DMAEn = 1'b0; DMAWrEn = 1'b0;
  endtask

  task automatic dma_rd(input logic [31:0] a);
    DMAEn = 1'b1; DMAWrEn = 1'b0; DMAAddr = a;
    tick();
    DMAEn = 1'b0;
  endtask

  task automatic cpu_acc(input logic wr, input logic [31:0] a, input logic [31:0] d);
    cpu_en = 1'b1; cpu_wr_en = wr; cpu_addr = a; cpu_wdata = d;
    tick();
    cpu_en = 1'b0; cpu_wr_en = 1'b0;
  endtask

  initial begin
    vec_t v;
    int   n;
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_data_to_host", data_to_host, 32'h0);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_wr_ready", {31'h0, wr_ready}, 32'h0);
    chk("rst_line_irq", {31'h0, line_irq}, 32'h0);
    rst_n = 1'b1;
    tick();

    // Build the vector table: a full line in, status, doorbell, a full line out.
    n = 0;
    for (int i = 0; i < 16; i++) begin
      v = '{default: '0};
      v.dma_en = 1'b1; v.dma_wr = 1'b1;
      v.dma_addr = 32'h5000 + 32'(4 * i); v.dma_wdata = 32'hA0 + 32'(i);
      v.exp_irq = (i == 15);
      vecs[n] = v; n++;
    end
    v = '{default: '0};
    v.cpu_en = 1'b1; v.cpu_addr = 32'h5008; v.chk_crd = 1'b1; v.exp_crd = 32'hA2; v.exp_irq = 1'b1;
    vecs[n] = v; n++;
    v = '{default: '0};
    v.cpu_en = 1'b1; v.cpu_addr = 32'h5044; v.chk_crd = 1'b1; v.exp_crd = 32'h1; v.exp_irq = 1'b1;
    vecs[n] = v; n++;
    v = '{default: '0};
    v.cpu_en = 1'b1; v.cpu_wr = 1'b1; v.cpu_addr = 32'h5040; v.cpu_wdata = 32'h1;
    v.exp_wr_ready = 1'b1; v.exp_irq = 1'b1;
    vecs[n] = v; n++;
    v = '{default: '0};
    v.cpu_en = 1'b1; v.cpu_addr = 32'h5044; v.chk_crd = 1'b1; v.exp_crd = 32'h3;
    v.exp_wr_ready = 1'b1; v.exp_irq = 1'b1;
    vecs[n] = v; n++;
    for (int k = 0; k < 16; k++) begin
      v = '{default: '0};
      v.dma_en = 1'b1; v.dma_addr = 32'h5000 + 32'(4 * k);
      v.chk_dth = 1'b1; v.exp_dth = 32'hA0 + 32'(k); v.exp_irq = 1'b1;
      vecs[n] = v; n++;
    end
    v = '{default: '0};
    v.cpu_en = 1'b1; v.cpu_addr = 32'h5044; v.chk_crd = 1'b1; v.exp_crd = 32'h1; v.exp_irq = 1'b1;
    vecs[n] = v; n++;

    for (int i = 0; i < n; i++) begin
      DMAEn = vecs[i].dma_en; DMAWrEn = vecs[i].dma_wr;
      DMAAddr = vecs[i].dma_addr; data_to_mem = vecs[i].dma_wdata;
      cpu_en = vecs[i].cpu_en; cpu_wr_en = vecs[i].cpu_wr;
      cpu_addr = vecs[i].cpu_addr; cpu_wdata = vecs[i].cpu_wdata;
      tick();
      if (vecs[i].chk_dth) chk($sformatf("vec%0d_data_to_host", i), data_to_host, vecs[i].exp_dth);
      if (vecs[i].chk_crd) chk($sformatf("vec%0d_cpu_rdata", i), cpu_rdata, vecs[i].exp_crd);
      chk($sformatf("vec%0d_wr_ready", i), {31'h0, wr_ready}, {31'h0, vecs[i].exp_wr_ready});
      chk($sformatf("vec%0d_line_irq", i), {31'h0, line_irq}, {31'h0, vecs[i].exp_irq});
      chk($sformatf("vec%0d_cpu_stall", i), {31'h0, cpu_stall}, {31'h0, vecs[i].exp_stall});
    end
    idle_inputs();

    // Collision: DMA wins, CPU write is held and lands once the DMA goes quiet.
    DMAEn = 1'b1; DMAWrEn = 1'b1; DMAAddr = 32'h5014; data_to_mem = 32'h5678;
    cpu_en = 1'b1; cpu_wr_en = 1'b1; cpu_addr = 32'h5010; cpu_wdata = 32'h1234;
    #1;
    chk("coll_stall_comb", {31'h0, cpu_stall}, 32'h1);
    tick();
    DMAWrEn = 1'b0; DMAAddr = 32'h5010;
    tick();
    chk("coll_held_not_landed", data_to_host, 32'hA4);
    chk("coll_stall_again", {31'h0, cpu_stall}, 32'h1);
    DMAEn = 1'b0;
    tick();
    chk("coll_stall_released", {31'h0, cpu_stall}, 32'h0);
    cpu_en = 1'b0; cpu_wr_en = 1'b0;
    cpu_acc(1'b0, 32'h5010, 32'h0);
    chk("coll_cpu_word", cpu_rdata, 32'h1234);
    cpu_acc(1'b0, 32'h5014, 32'h0);
    chk("coll_dma_word", cpu_rdata, 32'h5678);

    // Second line without clearing: rx_count is 1, 15 more writes wrap it.
    for (int i = 0; i < 15; i++) dma_wr(32'h5018, 32'(i));
    cpu_acc(1'b0, 32'h5044, 32'h0);
    chk("overrun_status", cpu_rdata, 32'h5);
    cpu_acc(1'b1, 32'h5044, 32'h1);
    chk("clear_line_irq", {31'h0, line_irq}, 32'h0);
    cpu_acc(1'b0, 32'h5044, 32'h0);
    chk("clear_status", cpu_rdata, 32'h0);
    for (int i = 0; i < 15; i++) dma_wr(32'h5018, 32'(i));
    cpu_acc(1'b0, 32'h5044, 32'h0);
    chk("rx15_status", cpu_rdata, 32'h78);
    DMAEn = 1'b1; DMAWrEn = 1'b1; DMAAddr = 32'h5018; data_to_mem = 32'h0;
    cpu_en = 1'b1; cpu_wr_en = 1'b1; cpu_addr = 32'h5044; cpu_wdata = 32'h1;
    tick();
    chk("set_beats_clear_irq", {31'h0, line_irq}, 32'h1);
    chk("set_beats_clear_stall", {31'h0, cpu_stall}, 32'h1);
    DMAEn = 1'b0; DMAWrEn = 1'b0;
    tick();
    cpu_en = 1'b0; cpu_wr_en = 1'b0;
    chk("held_clear_lands", {31'h0, line_irq}, 32'h0);

    // Doorbell during TX is ignored.
    cpu_acc(1'b1, 32'h5040, 32'h1);
    chk("tx2_wr_ready_up", {31'h0, wr_ready}, 32'h1);
    dma_rd(32'h5000);
    chk("tx2_first_word", data_to_host, 32'hA0);
    chk("tx2_wr_ready_down", {31'h0, wr_ready}, 32'h0);
    cpu_acc(1'b1, 32'h5040, 32'h1);
    chk("tx2_doorbell_ignored", {31'h0, wr_ready}, 32'h0);
    cpu_acc(1'b0, 32'h5044, 32'h0);
    chk("tx2_busy_status", cpu_rdata, 32'h2);
    for (int k = 1; k < 16; k++) dma_rd(32'h5000 + 32'(4 * k));
    chk("tx2_last_word", data_to_host, 32'hAF);
    tick();
    chk("tx2_wr_ready_after", {31'h0, wr_ready}, 32'h0);
    cpu_acc(1'b0, 32'h5044, 32'h0);
    chk("tx2_idle_status", cpu_rdata, 32'h0);

    // Reset in the middle of a line.
    cpu_acc(1'b1, 32'h5040, 32'h1);
    for (int i = 0; i < 7; i++) dma_wr(32'h5000 + 32'(4 * i), 32'(i));
    cpu_acc(1'b0, 32'h5044, 32'h0);
    chk("pre_rst_status", cpu_rdata, 32'h3A);
    chk("pre_rst_wr_ready", {31'h0, wr_ready}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_ready", {31'h0, wr_ready}, 32'h0);
    chk("mid_rst_line_irq", {31'h0, line_irq}, 32'h0);
    chk("mid_rst_cpu_rdata", cpu_rdata, 32'h0);
    tick();
    rst_n = 1'b1;
    cpu_acc(1'b0, 32'h5044, 32'h0);
    chk("post_rst_status", cpu_rdata, 32'h0);

    // Out-of-window DMA access touches nothing in the window.
    dma_wr(32'h5000, 32'h77);
    dma_wr(32'h6000, 32'hDEAD);
`ifdef DMA_MEM_PORT_OOB_ERR_EN
    chk("oob_err_set", {31'h0, oob_err}, 32'h1);
`endif
    dma_rd(32'h6000);
    chk("oob_read_zero", data_to_host, 32'h0);
    cpu_acc(1'b0, 32'h5000, 32'h0);
    chk("oob_word0_kept", cpu_rdata, 32'h77);
    cpu_acc(1'b0, 32'h5044, 32'h0);
    chk("oob_status", cpu_rdata, 32'h08 | OOB_BIT);
`ifdef DMA_MEM_PORT_OOB_ERR_EN
    cpu_acc(1'b1, 32'h5044, 32'h2);
    chk("oob_err_cleared", {31'h0, oob_err}, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
